// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter
// Shares one RGB LED between two level-sensitive requesters and an idle
// colour rotation. Ownership is granted round-robin. Each grant is held for
// at least DWELL_CYCLES cycles so that a colour stays visible.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   req0 / req1    requester wants the LED (level)
//   color0/color1  requested colour, {R,G,B}
//   gnt0 / gnt1    requester currently owns the LED (never both high)
//   busy           gnt0 | gnt1
//   RGB_R/G/B      LED pins, 1 = lit
// All outputs come straight from flops.
module rgb_led_arbiter #(
    parameter int unsigned DWELL_CYCLES = 2000000,
    parameter int unsigned IDLE_STEP    = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [2:0] color0,
    input  logic       req1,
    input  logic [2:0] color1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    typedef enum logic [1:0] {PH_R, PH_B, PH_G} phase_t;

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] IDLE_LAST  = 32'(IDLE_STEP - 1);

    state_t      state, state_nxt;
    phase_t      phase, phase_nxt;
    logic [31:0] idle_cnt, idle_nxt;
    logic [31:0] dwell_cnt, dwell_nxt;
    logic        prio1, prio_nxt;   // 1: requester 1 wins the next tie
    logic [2:0]  led, led_nxt;

    function automatic logic [2:0] phase_color(phase_t p);
        case (p)
            PH_B:    return 3'b001;
            PH_G:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic phase_t phase_next(phase_t p);
        case (p)
            PH_R:    return PH_B;
            PH_B:    return PH_G;
            default: return PH_R;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        idle_nxt  = idle_cnt;
        dwell_nxt = dwell_cnt;
        prio_nxt  = prio1;
        led_nxt   = led;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || !prio1)) begin
                    state_nxt = OWN0;
                    dwell_nxt = '0;
                    led_nxt   = color0;
                    prio_nxt  = 1'b1;
                end else if (req1) begin
                    state_nxt = OWN1;
                    dwell_nxt = '0;
                    led_nxt   = color1;
                    prio_nxt  = 1'b0;
                end else if (idle_cnt >= IDLE_LAST) begin
                    idle_nxt  = '0;
                    phase_nxt = phase_next(phase);
                    led_nxt   = phase_color(phase_next(phase));
                end else begin
                    idle_nxt  = idle_cnt + 32'd1;
                end
            end
            OWN0: begin
                // Colour follows the requester while it asserts, else holds.
                if (req0) led_nxt = color0;
                if (dwell_cnt < DWELL_LAST) begin
                    dwell_nxt = dwell_cnt + 32'd1;
                end else if (req1) begin
                    state_nxt = OWN1;
                    dwell_nxt = '0;
                    led_nxt   = color1;
                    prio_nxt  = 1'b0;
                end else if (!req0) begin
                    state_nxt = IDLE;
                    phase_nxt = PH_R;
                    idle_nxt  = '0;
                    led_nxt   = 3'b100;
                end
            end
            OWN1: begin
                if (req1) led_nxt = color1;
                if (dwell_cnt < DWELL_LAST) begin
                    dwell_nxt = dwell_cnt + 32'd1;
                end else if (req0) begin
                    state_nxt = OWN0;
                    dwell_nxt = '0;
                    led_nxt   = color0;
                    prio_nxt  = 1'b1;
                end else if (!req1) begin
                    state_nxt = IDLE;
                    phase_nxt = PH_R;
                    idle_nxt  = '0;
                    led_nxt   = 3'b100;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = PH_R;
                idle_nxt  = '0;
                led_nxt   = 3'b100;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= PH_R;
            idle_cnt  <= '0;
            dwell_cnt <= '0;
            prio1     <= 1'b0;
            led       <= 3'b100;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            idle_cnt  <= idle_nxt;
            dwell_cnt <= dwell_nxt;
            prio1     <= prio_nxt;
            led       <= led_nxt;
            // Grant flops track the next state so they align with the LED.
            gnt0      <= (state_nxt == OWN0);
            gnt1      <= (state_nxt == OWN1);
            busy      <= (state_nxt != IDLE);
        end
    end

    assign {RGB_R, RGB_G, RGB_B} = led;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Scoreboard bench: stimulus pushes the hand-computed output expected after
// each clock edge; a monitor pops and compares one entry per cycle.
// Instance a uses DWELL=4/IDLE_STEP=3, instance b uses DWELL=1.
module tb_rgb_led_arbiter;

    logic       clk = 1'b0;
    logic       reset, req0, req1;
    logic [2:0] color0, color1;
    logic       a_g0, a_g1, a_busy, a_r, a_g, a_b;
    logic       b_g0, b_g1, b_busy, b_r, b_g, b_b;

    always #5 clk = ~clk;

    rgb_led_arbiter #(.DWELL_CYCLES(4), .IDLE_STEP(3)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .color0(color0), .req1(req1), .color1(color1),
        .gnt0(a_g0), .gnt1(a_g1), .busy(a_busy),
        .RGB_R(a_r), .RGB_G(a_g), .RGB_B(a_b)
    );

    rgb_led_arbiter #(.DWELL_CYCLES(1), .IDLE_STEP(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .color0(color0), .req1(req1), .color1(color1),
        .gnt0(b_g0), .gnt1(b_g1), .busy(b_busy),
        .RGB_R(b_r), .RGB_G(b_g), .RGB_B(b_b)
    );

    typedef struct {
        bit         dut;   // 0: dut_a, 1: dut_b
        logic [5:0] v;     // {gnt0, gnt1, busy, R, G, B}
        string      name;
        int         idx;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_name = "";
    int    step_no  = 0;

    // Monitor: one entry per edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [5:0] act;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = e.dut ? {b_g0, b_g1, b_busy, b_r, b_g, b_b}
                        : {a_g0, a_g1, a_busy, a_r, a_g, a_b};
            n_checks++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s step %0d: got g0g1busy_rgb=%b required %b",
                          e.name, e.idx, act, e.v);
        end
    end

    task automatic step(input logic r, input logic q0, input logic [2:0] c0,
                        input logic q1, input logic [2:0] c1, input bit d,
                        input logic g0, input logic g1, input logic [2:0] led);
        exp_t e;
        reset  = r;
        req0   = q0;
        color0 = c0;
        req1   = q1;
        color1 = c1;
        e.dut  = d;
        e.v    = {g0, g1, g0 | g1, led};
        e.name = cur_name;
        e.idx  = step_no;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit d);
        step_no = 0;
        step(1, 0, 3'b000, 0, 3'b000, d, 0, 0, 3'b100);
    endtask

    initial begin
        logic [2:0] rot [12] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b010,
                                 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b001};
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; color0 = '0; color1 = '0;

        // 1: idle rotation after reset
        cur_name = "idle_rotation";
        do_reset(0);
        for (int i = 0; i < 12; i++) step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, rot[i]);

        // 2: one-cycle request, held for full dwell, then idle restarts at R
        cur_name = "single_dwell";
        do_reset(0);
        step(0, 1, 3'b011, 0, 3'b000, 0, 1, 0, 3'b011);
        for (int i = 0; i < 3; i++) step(0, 0, 3'b011, 0, 3'b000, 0, 1, 0, 3'b011);
        step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b100);
        step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b100);
        step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b100);
        step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b001);

        // 3: contention, round-robin with no gap
        cur_name = "contend";
        do_reset(0);
        for (int k = 0; k < 10; k++) begin
            if ((k / 4) % 2 == 0) step(0, 1, 3'b110, 1, 3'b101, 0, 1, 0, 3'b110);
            else                  step(0, 1, 3'b110, 1, 3'b101, 0, 0, 1, 3'b101);
        end

        // 4: requester 1 alone, colour tracks change, then release
        cur_name = "track_color";
        do_reset(0);
        for (int k = 0; k < 5; k++) step(0, 0, 3'b000, 1, 3'b001, 0, 0, 1, 3'b001);
        for (int k = 0; k < 5; k++) step(0, 0, 3'b000, 1, 3'b111, 0, 0, 1, 3'b111);
        step(0, 0, 3'b000, 0, 3'b111, 0, 0, 0, 3'b100);

        // 5: reset mid-grant, then a fresh full dwell
        cur_name = "reset_mid";
        do_reset(0);
        for (int k = 0; k < 3; k++) step(0, 1, 3'b010, 0, 3'b000, 0, 1, 0, 3'b010);
        step(1, 1, 3'b010, 0, 3'b000, 0, 0, 0, 3'b100);
        step(0, 1, 3'b010, 0, 3'b000, 0, 1, 0, 3'b010);
        for (int k = 0; k < 3; k++) step(0, 0, 3'b010, 0, 3'b000, 0, 1, 0, 3'b010);
        step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b100);

        // 7: after serving requester 1, requester 0 wins the next tie
        cur_name = "rr_pointer";
        do_reset(0);
        step(0, 0, 3'b000, 1, 3'b001, 0, 0, 1, 3'b001);
        for (int k = 0; k < 3; k++) step(0, 0, 3'b000, 0, 3'b110, 0, 0, 1, 3'b001);
        step(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b100);
        step(0, 1, 3'b011, 1, 3'b101, 0, 1, 0, 3'b011);

        // 6: DWELL_CYCLES = 1 alternates every cycle
        cur_name = "dwell1_alt";
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) step(0, 1, 3'b110, 1, 3'b101, 1, 1, 0, 3'b110);
            else            step(0, 1, 3'b110, 1, 3'b101, 1, 0, 1, 3'b101);
        end
        step(0, 0, 3'b000, 0, 3'b000, 1, 0, 0, 3'b100);

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
